// File: rtl/serial_rx_package_if.sv
// Serial receiver link: rx line in, assembled packet and status strobes out.
interface serial_rx_package_if #(
  parameter int AddressWidth = 2,
  parameter int WordWidth    = 8
);
  localparam int DataW = (2 ** AddressWidth) * WordWidth;

  logic             rx;
  logic [DataW-1:0] data;
  logic             valid;
  logic             busy;
  logic             frameError;
  logic             timeout;

  modport master (
    output rx,
    input  data, valid, busy, frameError, timeout
  );

  modport slave (
    input  rx,
    output data, valid, busy, frameError, timeout
  );
endinterface

// File: rtl/serial_rx_package.sv
// UART-style word receiver that assembles 2**AddressWidth words into a packet.
// Optional inter-word timeout enabled by SERIAL_RX_PACKAGE_TIMEOUT_EN.
module serial_rx_package #(
  parameter int AddressWidth     = 2,
  parameter int WordWidth        = 8,
  parameter int SerialTimerWidth = 8
) (
  input logic               clk,
  input logic               rst,
  serial_rx_package_if.slave bus
);
  localparam int DataW = (2 ** AddressWidth) * WordWidth;
  localparam int BitW  = $clog2(WordWidth) + 1;
  localparam int STW   = SerialTimerWidth;

  localparam logic [BitW-1:0] LastBit  = BitW'(WordWidth - 1);
  localparam logic [STW-1:0]  TimerMax = '1;
  localparam logic [STW-1:0]  HalfM1   = {1'b0, {(STW-1){1'b1}}};

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_HIGH
  } state_t;

  state_t            state_q, state_d;
  logic              rx_meta_q, rx_s_q, rx_prev_q;
  logic [STW-1:0]    timer_q, timer_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [WordWidth-1:0] shift_q, shift_d;
  logic [AddressWidth-1:0] cnt_q, cnt_d;
  logic [DataW-1:0]  buf_q, buf_d, word_buf;
  logic [DataW-1:0]  data_q, data_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              fe_q, fe_d;
  logic              fall;

`ifdef SERIAL_RX_PACKAGE_TIMEOUT_EN
  logic [STW+3:0]    idle_q, idle_d;
  logic              to_q, to_d;
`endif

  assign fall = rx_prev_q & ~rx_s_q;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    data_d   = data_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    fe_d     = 1'b0;
    // First word lands in the most-significant slot
    word_buf = buf_q;
    word_buf[int'(~cnt_q) * WordWidth +: WordWidth] = shift_q;

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (timer_q == HalfM1) begin
          timer_d = '0;
          bit_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer_q == TimerMax) begin
          shift_d = {rx_s_q, shift_q[WordWidth-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LastBit) state_d = STOP;
        end
      end
      STOP: begin
        if (timer_q == TimerMax) begin
          if (rx_s_q) begin
            state_d = IDLE;
            buf_d   = word_buf;
            if (&cnt_q) begin
              data_d  = word_buf;
              valid_d = 1'b1;
              busy_d  = 1'b0;
              cnt_d   = '0;
            end else begin
              busy_d  = 1'b1;
              cnt_d   = cnt_q + 1'b1;
            end
          end else begin
            fe_d    = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        timer_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef SERIAL_RX_PACKAGE_TIMEOUT_EN
    idle_d = '0;
    to_d   = 1'b0;
    if (busy_q && state_q == IDLE) begin
      idle_d = idle_q + 1'b1;
      if (&idle_q) begin
        to_d   = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
        idle_d = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
    end
  end

`ifdef SERIAL_RX_PACKAGE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      idle_q <= '0;
      to_q   <= 1'b0;
    end else begin
      idle_q <= idle_d;
      to_q   <= to_d;
    end
  end

  assign bus.timeout = to_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.data       = data_q;
  assign bus.valid      = valid_q;
  assign bus.busy       = busy_q;
  assign bus.frameError = fe_q;
endmodule

// File: tb/tb_serial_rx_package.sv
// Directed bench for serial_rx_package: packet table plus glitch,
// frame-error, reset-abort and inter-word timeout sequences.
module tb_serial_rx_package;
  localparam int AW  = 2;
  localparam int WW  = 8;
  localparam int STW = 4;
  localparam int BIT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_rx_package_if #(.AddressWidth(AW), .WordWidth(WW)) bus ();

  serial_rx_package #(
    .AddressWidth(AW),
    .WordWidth(WW),
    .SerialTimerWidth(STW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Strobe monitor
  int   vcnt = 0, fcnt = 0, tcnt = 0;
  int   width_err = 0, mutex_err = 0;
  logic pv = 1'b0, pf = 1'b0, pt = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.valid) vcnt++;
      if (bus.frameError) fcnt++;
      if (bus.timeout) tcnt++;
      if ((bus.valid && pv) || (bus.frameError && pf) ||
          (bus.timeout && pt))
        width_err++;
      if (int'(bus.valid) + int'(bus.frameError) +
          int'(bus.timeout) > 1)
        mutex_err++;
    end
    pv = bus.valid;
    pf = bus.frameError;
    pt = bus.timeout;
  end

  task automatic hold(input logic v, input int n);
    bus.rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(b[i], BIT);
    hold(stop, BIT);
  endtask

  typedef struct {
    logic [7:0]  w0, w1, w2, w3;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [4];
  int   v0, f0, t0;

  initial begin
    tbl[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h11223344};
    tbl[1] = '{8'hA5, 8'h5A, 8'hFF, 8'h00, 32'hA55AFF00};
    tbl[2] = '{8'h80, 8'h01, 8'h7E, 8'hC3, 32'h80017EC3};
    tbl[3] = '{8'h00, 8'h00, 8'h00, 8'h01, 32'h00000001};

    bus.rx = 1'b1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_data", bus.data, 32'h0);
    check("rst_valid", 32'(bus.valid), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_fe", 32'(bus.frameError), 32'h0);
    check("rst_timeout", 32'(bus.timeout), 32'h0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      v0 = vcnt;
      f0 = fcnt;
      send(tbl[i].w0, 1'b1);
      send(tbl[i].w1, 1'b1);
      send(tbl[i].w2, 1'b1);
      send(tbl[i].w3, 1'b1);
      repeat (4) @(negedge clk);
      check($sformatf("pkt%0d_data", i), bus.data, tbl[i].exp);
      check($sformatf("pkt%0d_valid", i), 32'(vcnt - v0), 32'd1);
      check($sformatf("pkt%0d_fe", i), 32'(fcnt - f0), 32'd0);
      check($sformatf("pkt%0d_busy", i), 32'(bus.busy), 32'h0);
    end

    // Short low glitch between words of a packet
    v0 = vcnt;
    f0 = fcnt;
    send(8'h11, 1'b1);
    hold(1'b0, 4);
    hold(1'b1, 40);
    check("glitch_strobes", 32'(vcnt - v0 + fcnt - f0), 32'd0);
    check("glitch_busy", 32'(bus.busy), 32'h1);
    check("glitch_data", bus.data, 32'h00000001);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    send(8'h44, 1'b1);
    repeat (4) @(negedge clk);
    check("glitch_pkt", bus.data, 32'h11223344);
    check("glitch_valid", 32'(vcnt - v0), 32'd1);

    // Bad stop bit aborts the partial packet
    v0 = vcnt;
    f0 = fcnt;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h99, 1'b0);
    hold(1'b1, 20);
    check("fe_count", 32'(fcnt - f0), 32'd1);
    check("fe_busy", 32'(bus.busy), 32'h0);
    check("fe_data", bus.data, 32'h11223344);
    check("fe_novalid", 32'(vcnt - v0), 32'd0);
    send(8'hA1, 1'b1);
    send(8'hB2, 1'b1);
    send(8'hC3, 1'b1);
    send(8'hD4, 1'b1);
    repeat (4) @(negedge clk);
    check("fe_next_pkt", bus.data, 32'hA1B2C3D4);
    check("fe_next_valid", 32'(vcnt - v0), 32'd1);

    // Reset during bit 3 of the second frame
    send(8'h55, 1'b1);
    hold(1'b0, BIT);
    hold(1'b0, BIT);
    hold(1'b1, BIT);
    hold(1'b0, BIT);
    bus.rx = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_data", bus.data, 32'h0);
    check("mid_rst_valid", 32'(bus.valid), 32'h0);
    check("mid_rst_busy", 32'(bus.busy), 32'h0);
    check("mid_rst_fe", 32'(bus.frameError), 32'h0);
    check("mid_rst_to", 32'(bus.timeout), 32'h0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    v0 = vcnt;
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    send(8'h03, 1'b1);
    send(8'h04, 1'b1);
    repeat (4) @(negedge clk);
    check("post_rst_pkt", bus.data, 32'h01020304);
    check("post_rst_valid", 32'(vcnt - v0), 32'd1);

    // Inter-word gap after a single word
    t0 = tcnt;
    send(8'h55, 1'b1);
    hold(1'b1, 300);
`ifdef SERIAL_RX_PACKAGE_TIMEOUT_EN
    check("to_count", 32'(tcnt - t0), 32'd1);
    check("to_busy", 32'(bus.busy), 32'h0);
`else
    check("to_count", 32'(tcnt - t0), 32'd0);
    check("to_busy", 32'(bus.busy), 32'h1);
`endif
    check("to_data", bus.data, 32'h01020304);

    check("strobe_width", 32'(width_err), 32'd0);
    check("strobe_mutex", 32'(mutex_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_rx_package.md
SERIAL_RX_PACKAGE -- requirements
Module: serial_rx_package

Interface
REQ-001 SHALL have parameter AddressWidth, default 2, log2 of words per packet.
REQ-002 SHALL have parameter WordWidth, default 8, data bits per serial frame.
REQ-003 SHALL have parameter SerialTimerWidth, default 8; bit period = 2**SerialTimerWidth clk cycles.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port data  output  2**AddressWidth*WordWidth  last complete packet.
REQ-008 SHALL have port valid  output  1  one-cycle strobe: data just updated.
REQ-009 SHALL have port busy  output  1  high while a packet is partially received.
REQ-010 SHALL have port frameError  output  1  one-cycle strobe: bad stop bit.
REQ-011 SHALL have port timeout  output  1  one-cycle strobe: packet aborted on inter-word gap.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer (reset value 1); all references to rx below mean the synchronized signal.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: 1->0 transition on rx SHALL enter START and clear the bit timer.
REQ-015 START: after 2**(SerialTimerWidth-1) cycles sample rx; 0 -> DATA, 1 -> IDLE (glitch, no strobe, packet state untouched).
REQ-016 DATA: SHALL sample rx every 2**SerialTimerWidth cycles, WordWidth samples, LSB first, then enter STOP.
REQ-017 STOP: after one further bit period sample rx; 1 -> word accepted, IDLE; 0 -> frameError pulse, WAIT_HIGH.
REQ-018 WAIT_HIGH: SHALL return to IDLE on first cycle rx = 1.
REQ-019 Word index counter SHALL be AddressWidth bits; accepted word stored at slot ~counter (first word in most-significant slot, matching the packet transmitter's ordering).
REQ-020 On accepting the word with counter all-ones, SHALL copy the full buffer to data and assert valid the next cycle, and SHALL wrap counter to 0.
REQ-021 data SHALL hold its value between packets; partial packets SHALL never alter data.
REQ-022 frameError SHALL reset counter to 0 and discard the partial packet.
REQ-023 busy SHALL be high from acceptance of the first word until the packet completes or aborts.
REQ-024 valid, frameError, timeout SHALL be mutually exclusive and never longer than one cycle.

Reset
REQ-025 While rst = 0 at a clk edge: state IDLE, timer 0, counter 0, buffer 0, data 0, valid/busy/frameError/timeout 0, synchronizer 1.
REQ-026 Reset mid-frame or mid-packet SHALL discard all partial state; the next start edge after release begins a fresh packet at slot ~0.

Configuration
REQ-027 Macro SERIAL_RX_PACKAGE_TIMEOUT_EN defined: while busy and state IDLE, an idle count reaching 2**(SerialTimerWidth+4) cycles SHALL pulse timeout, reset counter, drop busy.
REQ-028 Macro undefined: no idle counter logic; timeout SHALL be constant 0; partial packets wait indefinitely.

Verification (SerialTimerWidth=4, bit = 16 clk, AddressWidth=2, WordWidth=8)
REQ-029 Frames 0x11,0x22,0x33,0x44 back-to-back -> data = 0x11223344, valid high exactly one cycle, busy low after.
REQ-030 rx low for 4 cycles then high -> no strobe, counter unchanged, busy unchanged.
REQ-031 0x11,0x22 then frame with stop bit 0 -> frameError one cycle, busy 0; then 0xA1,0xB2,0xC3,0xD4 -> data = 0xA1B2C3D4.
REQ-032 rst = 0 during bit 3 of second frame, release, send 0x01,0x02,0x03,0x04 -> data = 0x01020304, outputs 0 during reset.
REQ-033 With SERIAL_RX_PACKAGE_TIMEOUT_EN: 0x55 then 300 idle cycles -> timeout one cycle after 256 idle cycles, busy 0, data unchanged; without macro -> no timeout, busy stays 1.
